serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl_pkg.sv | 12 +
 rtl/serial_add_ctrl_fa.sv | 16 +
 rtl/serial_add_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full-adder cell: the only arithmetic in the serial adder.
module serial_add_ctrl_fa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    // Single-bit sum and carry
    always_comb begin
        sum   = a ^ b ^ c;
        carry = (a & b) | (c & (a ^ b));
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one full-adder step per cycle, LSB first.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned    CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             shift_en;
    logic             finish;
    logic             fa_sum;
    logic             fa_carry;

    // Operand registers shift right, so the current bit k is always at index 0
    serial_add_ctrl_fa u_fa (
        .a     (op_a[0]),
        .b     (op_b[0]),
        .c     (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, control strobes and status outputs.
    // RUN spends WIDTH cycles shifting, then one cycle with cnt == WIDTH that
    // commits the result, so the count never wraps and DONE sees final values.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        finish     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end else begin
                    shift_en = 1'b1;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, serial add step, carry flop and bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            op_a  <= a;
            op_b  <= b;
            acc   <= '0;
            carry <= cin;
            cnt   <= '0;
        end else if (shift_en) begin
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            acc   <= {fa_sum, acc[WIDTH-1:1]};
            carry <= fa_carry;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Result registers hold until the next completed addition
    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (finish) begin
            sum  <= acc;
            cout <= carry;
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle, scramble inputs after capture, wait for done.
    // lat is the cycle index (1 = cycle after the accept edge) of the done pulse, 0 on timeout.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                         output logic [7:0] rs, output logic rc, output int lat, output logic b1);
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        lat = 0; b1 = 1'b0; rs = 'x; rc = 1'bx;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) b1 = busy;
            if (done) begin
                lat = i; rs = sum; rc = cout;
                break;
            end
        end
    endtask

    initial begin
        logic [7:0] rs;
        logic       rc;
        int         lat;
        logic       b1;
        int         dones;
        int         bad;
        logic [7:0] ra, rb;
        logic       rcin;
        logic [8:0] exp9;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_sum",  32'(sum),  0);
        check("reset_cout", 32'(cout), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 0x0F + 0x01
        do_op(8'h0F, 8'h01, 1'b0, rs, rc, lat, b1);
        check("basic_lat",  32'(lat), 10);
        check("basic_busy", 32'(b1),  1);
        check("basic_busy_in_done", 32'(busy), 0);
        check("basic_sum",  32'(rs),  32'h10);
        check("basic_cout", 32'(rc),  0);
        @(negedge clk);
        check("after_done_pulse", 32'(done), 0);
        check("after_done_busy",  32'(busy), 0);
        check("hold_sum_idle",    32'(sum),  32'h10);

        // Carry ripple through all bits
        do_op(8'hFF, 8'h01, 1'b0, rs, rc, lat, b1);
        check("ff01_sum",  32'(rs), 32'h00);
        check("ff01_cout", 32'(rc), 1);
        do_op(8'hFF, 8'hFF, 1'b1, rs, rc, lat, b1);
        check("ffff1_sum",  32'(rs), 32'hFF);
        check("ffff1_cout", 32'(rc), 1);
        @(negedge clk);

        // Start during RUN is ignored
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0; lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 2) begin start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1; end
            if (i == 3) begin start = 1'b0; a = 8'hA5; b = 8'h5A; end
            if (i == 5) check("hold_sum_run", 32'(sum), 32'hFF);
            if (done) begin
                dones++;
                if (lat == 0) lat = i;
                rs = sum; rc = cout;
            end
        end
        check("ignore_dones", 32'(dones), 1);
        check("ignore_lat",   32'(lat),   10);
        check("ignore_sum",   32'(rs),    32'h46);
        check("ignore_cout",  32'(rc),    0);

        // Reset aborts a run in progress
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_sum",  32'(sum),  0);
        check("abort_cout", 32'(cout), 0);
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones), 0);
        do_op(8'h01, 8'h01, 1'b0, rs, rc, lat, b1);
        check("post_abort_sum", 32'(rs),  32'h02);
        check("post_abort_lat", 32'(lat), 10);
        @(negedge clk);

        // Reset wins over start on the same edge
        rst = 1'b1; start = 1'b1; a = 8'h11; b = 8'h22;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_over_start_busy", 32'(busy), 0);
        check("rst_over_start_sum",  32'(sum),  0);

        // Start held high: back-to-back operations
        a = 8'h03; b = 8'h04; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        dones = 0; bad = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (busy == done) bad++;
            if (done) begin
                dones++;
                check("b2b_lat", 32'(i),   32'(10 * dones));
                check("b2b_sum", 32'(sum), 32'h08);
            end
            if (i == 30) start = 1'b0;
        end
        check("b2b_dones", 32'(dones), 3);
        check("b2b_busy_pattern", 32'(bad), 0);
        @(negedge clk);
        check("b2b_idle", 32'(busy), 0);

        // Randomized scoreboard
        for (int n = 0; n < 500; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rcin = 1'($urandom);
            exp9 = {1'b0, ra} + {1'b0, rb} + {8'b0, rcin};
            do_op(ra, rb, rcin, rs, rc, lat, b1);
            check("rand_result", 32'({rc, rs}), 32'(exp9));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
